// File: rtl/ocd_mem_responder.sv
// ocd_mem_responder
//
// Purpose:
//   Responder end of the on-chip-debug memory interface. Services one-cycle
//   read/write pulses from the hardware loader against the single-port
//   program/data RAM, which it shares with the CPU load/store path. OCD
//   traffic always wins the RAM port; the CPU is stalled through
//   cpu_mem_ack until its request can be issued and completed.
//
// Ports:
//   clk, reset_n                 single clock, synchronous active-low reset
//   ocd_read_enable/write_enable one-cycle OCD request pulses
//   ocd_rw_addr, ocd_write_word  OCD word address and full-word write data
//   ocd_mem_enable_out           one-cycle strobe marking valid OCD read data
//   ocd_mem_word_out             OCD read data, held between strobes
//   ocd_proto_err                sticky: OCD read and write in the same cycle
//   cpu_mem_*                    CPU request (held until ack), ack and read data
//   mem_*                        registered RAM port, plus mem_read_data return
module ocd_mem_responder #(
  parameter int MEM_ADDR_BITS = 14,
  parameter int XLEN          = 32,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ocd_read_enable,
  input  logic                     ocd_write_enable,
  input  logic [MEM_ADDR_BITS-1:0] ocd_rw_addr,
  input  logic [XLEN-1:0]          ocd_write_word,
  output logic                     ocd_mem_enable_out,
  output logic [XLEN-1:0]          ocd_mem_word_out,
  output logic                     ocd_proto_err,
  input  logic [MEM_ADDR_BITS-1:0] cpu_mem_addr,
  input  logic                     cpu_mem_read_en,
  input  logic                     cpu_mem_write_en,
  input  logic [XLEN/8-1:0]        cpu_mem_byte_enable,
  input  logic [XLEN-1:0]          cpu_mem_write_data,
  output logic                     cpu_mem_ack,
  output logic [XLEN-1:0]          cpu_mem_read_data,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic                     mem_read_en,
  output logic                     mem_write_en,
  output logic [XLEN/8-1:0]        mem_byte_enable,
  output logic [XLEN-1:0]          mem_write_data,
  input  logic [XLEN-1:0]          mem_read_data
);

  localparam int BeW = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE,
    CPU_WR,
    CPU_RD_WAIT
  } state_t;

  state_t                   r_state;
  logic [READ_LATENCY:0]    r_tagValid;
  logic [READ_LATENCY:0]    r_tagCpu;
  logic [MEM_ADDR_BITS-1:0] r_memAddr;
  logic                     r_memReadEn;
  logic                     r_memWriteEn;
  logic [BeW-1:0]           r_memByteEnable;
  logic [XLEN-1:0]          r_memWriteData;
  logic                     r_ocdStrobe;
  logic [XLEN-1:0]          r_ocdWord;
  logic                     r_protoErr;
  logic                     r_cpuAck;
  logic [XLEN-1:0]          r_cpuReadData;

  logic w_ocdAny;
  logic w_cpuReq;
  logic w_cpuGrant;
  logic w_issueRead;
  logic w_retValid;
  logic w_retCpu;

  // The CPU is only considered when no OCD pulse is present this cycle and
  // its previous operation has fully completed. The ack cycle itself is
  // excluded because the CPU still presents the finished request during it.
  assign w_ocdAny    = ocd_read_enable | ocd_write_enable;
  assign w_cpuReq    = cpu_mem_read_en | cpu_mem_write_en;
  assign w_cpuGrant  = ~w_ocdAny & w_cpuReq & (r_state == IDLE) & ~r_cpuAck;
  assign w_issueRead = ocd_read_enable | (w_cpuGrant & ~cpu_mem_write_en);

  // The oldest tag stage lines up with the cycle in which the RAM presents
  // the data for that read, so the owner bit steers it to OCD or CPU.
  assign w_retValid  = r_tagValid[READ_LATENCY];
  assign w_retCpu    = r_tagCpu[READ_LATENCY];

  // Single sequential block: arbiter, RAM port registers, tag pipeline,
  // CPU state machine and the registered response outputs. Strobes default
  // low every cycle so each pulse lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_tagValid      <= '0;
      r_tagCpu        <= '0;
      r_memAddr       <= '0;
      r_memReadEn     <= 1'b0;
      r_memWriteEn    <= 1'b0;
      r_memByteEnable <= '0;
      r_memWriteData  <= '0;
      r_ocdStrobe     <= 1'b0;
      r_ocdWord       <= '0;
      r_protoErr      <= 1'b0;
      r_cpuAck        <= 1'b0;
      r_cpuReadData   <= '0;
    end else begin
      r_memReadEn  <= 1'b0;
      r_memWriteEn <= 1'b0;
      r_ocdStrobe  <= 1'b0;
      r_cpuAck     <= 1'b0;
      r_tagValid   <= {r_tagValid[READ_LATENCY-1:0], w_issueRead};
      r_tagCpu     <= {r_tagCpu[READ_LATENCY-1:0], w_cpuGrant};

      if (ocd_read_enable) begin
        r_memAddr   <= ocd_rw_addr;
        r_memReadEn <= 1'b1;
        if (ocd_write_enable) begin
          r_protoErr <= 1'b1;
        end
      end else if (ocd_write_enable) begin
        r_memAddr       <= ocd_rw_addr;
        r_memWriteEn    <= 1'b1;
        r_memByteEnable <= {BeW{1'b1}};
        r_memWriteData  <= ocd_write_word;
      end else if (w_cpuGrant) begin
        r_memAddr <= cpu_mem_addr;
        if (cpu_mem_write_en) begin
          r_memWriteEn    <= 1'b1;
          r_memByteEnable <= cpu_mem_byte_enable;
          r_memWriteData  <= cpu_mem_write_data;
          r_cpuAck        <= 1'b1;
          r_state         <= CPU_WR;
        end else begin
          r_memReadEn <= 1'b1;
          r_state     <= CPU_RD_WAIT;
        end
      end

      if (r_state == CPU_WR) begin
        r_state <= IDLE;
      end

      if (w_retValid) begin
        if (w_retCpu) begin
          r_cpuReadData <= mem_read_data;
          r_cpuAck      <= 1'b1;
          r_state       <= IDLE;
        end else begin
          r_ocdWord   <= mem_read_data;
          r_ocdStrobe <= 1'b1;
        end
      end
    end
  end

  assign mem_addr           = r_memAddr;
  assign mem_read_en        = r_memReadEn;
  assign mem_write_en       = r_memWriteEn;
  assign mem_byte_enable    = r_memByteEnable;
  assign mem_write_data     = r_memWriteData;
  assign ocd_mem_enable_out = r_ocdStrobe;
  assign ocd_mem_word_out   = r_ocdWord;
  assign ocd_proto_err      = r_protoErr;
  assign cpu_mem_ack        = r_cpuAck;
  assign cpu_mem_read_data  = r_cpuReadData;

endmodule

// File: tb/tb_ocd_mem_responder.sv
// tb_ocd_mem_responder
//
// Drives two responders in lockstep on the same OCD pulses, one built with a
// one-cycle RAM and one with a three-cycle RAM, each attached to its own RAM
// model. A transaction-level reference keeps a memory image per instance and
// schedules the expected OCD strobes and CPU acks by edge number.
module tb_ocd_mem_responder;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetN;
  logic          ocdRd;
  logic          ocdWr;
  logic [AW-1:0] ocdAddr;
  logic [DW-1:0] ocdWdata;

  logic [AW-1:0] cpuAddr [2];
  logic          cpuRe [2];
  logic          cpuWe [2];
  logic [BW-1:0] cpuBe [2];
  logic [DW-1:0] cpuWd [2];

  logic          strobeA, protoA, ackA, memReA, memWeA;
  logic [DW-1:0] wordA, cpuRdA, memWdA, memRdataA;
  logic [AW-1:0] memAddrA;
  logic [BW-1:0] memBeA;
  logic          strobeB, protoB, ackB, memReB, memWeB;
  logic [DW-1:0] wordB, cpuRdB, memWdB, memRdataB;
  logic [AW-1:0] memAddrB;
  logic [BW-1:0] memBeB;

  ocd_mem_responder #(.MEM_ADDR_BITS(AW), .XLEN(DW), .READ_LATENCY(1)) dutA (
    .clk(clk), .reset_n(resetN),
    .ocd_read_enable(ocdRd), .ocd_write_enable(ocdWr),
    .ocd_rw_addr(ocdAddr), .ocd_write_word(ocdWdata),
    .ocd_mem_enable_out(strobeA), .ocd_mem_word_out(wordA), .ocd_proto_err(protoA),
    .cpu_mem_addr(cpuAddr[0]), .cpu_mem_read_en(cpuRe[0]), .cpu_mem_write_en(cpuWe[0]),
    .cpu_mem_byte_enable(cpuBe[0]), .cpu_mem_write_data(cpuWd[0]),
    .cpu_mem_ack(ackA), .cpu_mem_read_data(cpuRdA),
    .mem_addr(memAddrA), .mem_read_en(memReA), .mem_write_en(memWeA),
    .mem_byte_enable(memBeA), .mem_write_data(memWdA), .mem_read_data(memRdataA)
  );

  ocd_mem_responder #(.MEM_ADDR_BITS(AW), .XLEN(DW), .READ_LATENCY(3)) dutB (
    .clk(clk), .reset_n(resetN),
    .ocd_read_enable(ocdRd), .ocd_write_enable(ocdWr),
    .ocd_rw_addr(ocdAddr), .ocd_write_word(ocdWdata),
    .ocd_mem_enable_out(strobeB), .ocd_mem_word_out(wordB), .ocd_proto_err(protoB),
    .cpu_mem_addr(cpuAddr[1]), .cpu_mem_read_en(cpuRe[1]), .cpu_mem_write_en(cpuWe[1]),
    .cpu_mem_byte_enable(cpuBe[1]), .cpu_mem_write_data(cpuWd[1]),
    .cpu_mem_ack(ackB), .cpu_mem_read_data(cpuRdB),
    .mem_addr(memAddrB), .mem_read_en(memReB), .mem_write_en(memWeB),
    .mem_byte_enable(memBeB), .mem_write_data(memWdB), .mem_read_data(memRdataB)
  );

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = oldW;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = newW[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] initWord(input int a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // RAM models: data for a read appears the stated number of cycles after
  // the strobe; idle cycles push junk so a misaligned capture is visible.
  logic [DW-1:0] ramA [0:16383];
  logic [DW-1:0] ramB [0:16383];
  logic [DW-1:0] pipeA;
  logic [DW-1:0] pipeB [3];
  assign memRdataA = pipeA;
  assign memRdataB = pipeB[2];

  always @(posedge clk) begin
    if (memWeA) ramA[memAddrA] <= mergeBytes(ramA[memAddrA], memWdA, memBeA);
    if (memReA) pipeA <= ramA[memAddrA];
    else        pipeA <= $urandom;
  end

  always @(posedge clk) begin
    if (memWeB) ramB[memAddrB] <= mergeBytes(ramB[memAddrB], memWdB, memBeB);
    if (memReB) pipeB[0] <= ramB[memAddrB];
    else        pipeB[0] <= $urandom;
    pipeB[1] <= pipeB[0];
    pipeB[2] <= pipeB[1];
  end

  // Reference model state, one copy per instance.
  int            lat [2];
  logic [31:0]   mMem [2][64];
  bit            cpuActive [2];
  bit            cpuGranted [2];
  bit            cpuIsWr [2];
  bit            ackPrev [2];
  bit            expProto [2];
  logic [31:0]   expWord [2];
  bit            expStrobe [2][8];
  logic [31:0]   expStrobeWord [2][8];
  bit            expAck [2][8];
  bit            expAckRd [2][8];
  logic [31:0]   expAckData [2][8];
  int            edgeNo;
  int            compared;
  int            mismatched;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed=%h expected=%h (edge %0d)", tag, observed, expected, edgeNo);
    end
  endtask

  task automatic clearModel();
    for (int d = 0; d < 2; d++) begin
      cpuActive[d] = 0; cpuGranted[d] = 0; ackPrev[d] = 0;
      expProto[d] = 0; expWord[d] = '0;
      cpuRe[d] = 1'b0; cpuWe[d] = 1'b0;
      for (int s = 0; s < 8; s++) begin
        expStrobe[d][s] = 0; expAck[d][s] = 0; expAckRd[d][s] = 0;
      end
    end
  endtask

  // Decide what the upcoming edge grants, from the arbitration rules, and
  // schedule the resulting responses.
  task automatic modelEdge(input int d, input bit rd, input bit wr, input int a, input logic [31:0] wd);
    int s;
    int ca;
    ca = int'(cpuAddr[d][5:0]);
    if (rd) begin
      s = (edgeNo + lat[d] + 1) % 8;
      expStrobe[d][s] = 1;
      expStrobeWord[d][s] = mMem[d][a];
      if (wr) expProto[d] = 1;
    end else if (wr) begin
      mMem[d][a] = wd;
    end else if (cpuActive[d] && !cpuGranted[d]) begin
      cpuGranted[d] = 1;
      if (cpuIsWr[d]) begin
        mMem[d][ca] = mergeBytes(mMem[d][ca], cpuWd[d], cpuBe[d]);
        s = edgeNo % 8;
        expAck[d][s] = 1;
        expAckRd[d][s] = 0;
      end else begin
        s = (edgeNo + lat[d] + 1) % 8;
        expAck[d][s] = 1;
        expAckRd[d][s] = 1;
        expAckData[d][s] = mMem[d][ca];
      end
    end
  endtask

  task automatic checkCycle(input int d);
    int s;
    logic oS, oP, oA;
    logic [31:0] oW, oR;
    string p;
    s = edgeNo % 8;
    p = $sformatf("L%0d", lat[d]);
    if (d == 0) begin oS = strobeA; oP = protoA; oA = ackA; oW = wordA; oR = cpuRdA; end
    else        begin oS = strobeB; oP = protoB; oA = ackB; oW = wordB; oR = cpuRdB; end
    checkOutput({p, " ocd_strobe"}, {31'd0, oS}, {31'd0, expStrobe[d][s]});
    if (expStrobe[d][s]) expWord[d] = expStrobeWord[d][s];
    checkOutput({p, " ocd_word"}, oW, expWord[d]);
    checkOutput({p, " proto_err"}, {31'd0, oP}, {31'd0, expProto[d]});
    checkOutput({p, " cpu_ack"}, {31'd0, oA}, {31'd0, expAck[d][s]});
    if (expAck[d][s] && expAckRd[d][s]) checkOutput({p, " cpu_rdata"}, oR, expAckData[d][s]);
    if (ackPrev[d]) begin
      cpuActive[d] = 0; cpuGranted[d] = 0;
      cpuRe[d] = 1'b0; cpuWe[d] = 1'b0;
    end
    ackPrev[d] = expAck[d][s];
    expStrobe[d][s] = 0; expAck[d][s] = 0; expAckRd[d][s] = 0;
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input int a, input logic [31:0] wd);
    ocdRd = rd; ocdWr = wr; ocdAddr = AW'(a); ocdWdata = wd;
    edgeNo++;
    for (int d = 0; d < 2; d++) modelEdge(d, rd, wr, a, wd);
    @(posedge clk);
    @(negedge clk);
    ocdRd = 1'b0; ocdWr = 1'b0;
    for (int d = 0; d < 2; d++) checkCycle(d);
  endtask

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++) applyStimulus(0, 0, 0, '0);
  endtask

  task automatic startCpu(input int d, input bit isWr, input int a, input logic [3:0] be, input logic [31:0] wd);
    cpuActive[d] = 1; cpuGranted[d] = 0; cpuIsWr[d] = isWr;
    cpuAddr[d] = AW'(a); cpuBe[d] = be; cpuWd[d] = wd;
    cpuRe[d] = !isWr; cpuWe[d] = isWr;
  endtask

  task automatic randomCpu();
    for (int d = 0; d < 2; d++) begin
      if (!cpuActive[d]) begin
        if ($urandom_range(0, 99) < 30)
          startCpu(d, 1'($urandom_range(0, 1)), $urandom_range(0, 63), 4'($urandom), $urandom);
      end else if (!cpuGranted[d] && $urandom_range(0, 99) < 5) begin
        cpuActive[d] = 0; cpuRe[d] = 1'b0; cpuWe[d] = 1'b0;
      end
    end
  endtask

  task automatic applyReset();
    resetN = 1'b0; ocdRd = 1'b0; ocdWr = 1'b0;
    clearModel();
    edgeNo++;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst strobeA", {31'd0, strobeA}, 32'd0);
    checkOutput("rst wordA", wordA, 32'd0);
    checkOutput("rst protoA", {31'd0, protoA}, 32'd0);
    checkOutput("rst ackA", {31'd0, ackA}, 32'd0);
    checkOutput("rst cpuRdA", cpuRdA, 32'd0);
    checkOutput("rst memAddrA", {18'd0, memAddrA}, 32'd0);
    checkOutput("rst memEnA", {30'd0, memReA, memWeA}, 32'd0);
    checkOutput("rst memBeWdA", memWdA | {28'd0, memBeA}, 32'd0);
    checkOutput("rst strobeB", {31'd0, strobeB}, 32'd0);
    checkOutput("rst wordB", wordB, 32'd0);
    checkOutput("rst protoB", {31'd0, protoB}, 32'd0);
    checkOutput("rst ackB", {31'd0, ackB}, 32'd0);
    checkOutput("rst cpuRdB", cpuRdB, 32'd0);
    checkOutput("rst memAddrB", {18'd0, memAddrB}, 32'd0);
    checkOutput("rst memEnB", {30'd0, memReB, memWeB}, 32'd0);
    checkOutput("rst memBeWdB", memWdB | {28'd0, memBeB}, 32'd0);
    resetN = 1'b1;
  endtask

  initial begin
    int r;
    compared = 0; mismatched = 0; edgeNo = 0;
    lat[0] = 1; lat[1] = 3;
    resetN = 1'b0; ocdRd = 1'b0; ocdWr = 1'b0; ocdAddr = '0; ocdWdata = '0;
    for (int d = 0; d < 2; d++) begin
      cpuAddr[d] = '0; cpuBe[d] = '0; cpuWd[d] = '0;
      for (int a = 0; a < 64; a++) mMem[d][a] = initWord(a);
    end
    for (int a = 0; a < 16384; a++) begin
      ramA[a] <= initWord(a);
      ramB[a] <= initWord(a);
    end
    pipeA <= '0;
    for (int i = 0; i < 3; i++) pipeB[i] <= '0;
    clearModel();
    @(negedge clk);
    applyReset();
    applyReset();

    $display("[TB] OCD write then read");
    applyStimulus(0, 1, 'h10, 32'hDEADBEEF);
    idleCycles(3);
    applyStimulus(1, 0, 'h10, '0);
    idleCycles(5);
    checkOutput("t1 wordA", wordA, 32'hDEADBEEF);
    checkOutput("t1 wordB", wordB, 32'hDEADBEEF);

    $display("[TB] CPU/OCD collision");
    applyStimulus(0, 1, 'h20, 32'h11111111);
    applyStimulus(0, 1, 'h30, 32'h22222222);
    for (int d = 0; d < 2; d++) startCpu(d, 0, 'h20, 4'hF, '0);
    applyStimulus(1, 0, 'h30, '0);
    idleCycles(7);
    checkOutput("t2 cpuRdA", cpuRdA, 32'h11111111);
    checkOutput("t2 cpuRdB", cpuRdB, 32'h11111111);

    $display("[TB] CPU byte write");
    applyStimulus(0, 1, 'h08, 32'h12345678);
    for (int d = 0; d < 2; d++) startCpu(d, 1, 'h08, 4'b0010, 32'h0000AB00);
    idleCycles(3);
    applyStimulus(1, 0, 'h08, '0);
    idleCycles(5);
    checkOutput("t3 wordA", wordA, 32'h1234AB78);
    checkOutput("t3 wordB", wordB, 32'h1234AB78);

    $display("[TB] simultaneous read and write");
    applyStimulus(0, 1, 'h05, 32'hA5A5A5A5);
    applyStimulus(1, 1, 'h05, 32'hFFFFFFFF);
    idleCycles(5);
    applyStimulus(1, 0, 'h05, '0);
    idleCycles(5);
    checkOutput("t4 wordA", wordA, 32'hA5A5A5A5);
    checkOutput("t4 protoA", {31'd0, protoA}, 32'd1);

    $display("[TB] reset during read");
    applyStimulus(1, 0, 'h07, '0);
    applyReset();
    idleCycles(6);

    $display("[TB] OCD burst with CPU waiting");
    for (int d = 0; d < 2; d++) startCpu(d, 0, 'h03, 4'hF, '0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 'h30 + i, '0);
    idleCycles(8);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) applyReset();
      randomCpu();
      r = $urandom_range(0, 99);
      if (r < 30)      applyStimulus(1, 0, $urandom_range(0, 63), $urandom);
      else if (r < 45) applyStimulus(0, 1, $urandom_range(0, 63), $urandom);
      else if (r < 46) applyStimulus(1, 1, $urandom_range(0, 63), $urandom);
      else             applyStimulus(0, 0, 0, '0);
    end
    idleCycles(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
